// File: rtl/seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det
//  Description : Serial bit-pattern detector. A PAT_W-bit shift register holds
//                the most recent input bits and is compared against PATTERN
//                (oldest bit = PATTERN MSB). A match raises a one-cycle
//                registered pulse on out in the cycle after the edge that
//                sampled the last pattern bit.
//  Config      : SEQ_DET_NO_OVERLAP_EN - when defined, history and fill
//                count are cleared on a match, so matches cannot overlap.
//                When undefined (default), overlapping matches are reported.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
   input  logic clk,
   input  logic rst,
   input  logic In,
   output logic out
);

   // Fill counter saturates at PAT_W, so it needs enough bits to hold PAT_W.
   localparam int                c_FILL_W   = $clog2(PAT_W + 1);
   localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
   // Before the edge that completes a window, PAT_W-1 bits must already be in.
   localparam logic [c_FILL_W-1:0] c_FILL_ARM = c_FILL_W'(PAT_W - 1);
   localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

   logic [PAT_W-1:0]    r_hist;
   logic [c_FILL_W-1:0] r_fill;
   logic                r_out;

   logic [PAT_W-1:0]    w_nxt;
   logic                w_match;

   // Next history word and match decision; the fill qualifier keeps the
   // zeros left by reset from ever forming a match on their own.
   always_comb begin
      w_nxt   = {r_hist[PAT_W-2:0], In};
      w_match = (w_nxt == PATTERN) && (r_fill >= c_FILL_ARM);
   end

   // History shift, saturating fill count and registered detect pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist <= '0;
         r_fill <= '0;
         r_out  <= 1'b0;
      end else begin
         r_out <= w_match;
`ifdef SEQ_DET_NO_OVERLAP_EN
         if (w_match) begin
            // Restart framing: the next match needs PAT_W fresh bits.
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_nxt;
            if (r_fill != c_FILL_MAX) begin
               r_fill <= r_fill + c_FILL_ONE;
            end
         end
`else
         r_hist <= w_nxt;
         if (r_fill != c_FILL_MAX) begin
            r_fill <= r_fill + c_FILL_ONE;
         end
`endif
      end
   end

   assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det
//  Description : Scoreboard bench for seq_det (PAT_W=4, PATTERN=4'b1011).
//                The driver applies one bit per cycle and queues the expected
//                out value for the following cycle; a monitor pops and checks
//                one entry after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det;

   typedef struct {
      bit    exp;
      string tag;
      int    idx;
   } sb_entry_t;

   logic clk;
   logic rst;
   logic In;
   logic out;

   sb_entry_t sb_q[$];
   int        n_vec;
   int        n_bad;

   seq_det #(
      .PAT_W   (4),
      .PATTERN (4'b1011)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .In  (In),
      .out (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bit per cycle on the falling edge; exps[i] is the out value
   // expected right after the rising edge that samples bits[i].
   task automatic apply(input bit r, input string bits, input string exps, input string tag);
      sb_entry_t e;
      for (int i = 0; i < bits.len(); i++) begin
         @(negedge clk);
         rst = r;
         In  = (bits[i] == "1");
         e.exp = (exps[i] == "1");
         e.tag = tag;
         e.idx = i;
         sb_q.push_back(e);
      end
   endtask

   // Monitor: check out shortly after every rising edge that has a queued entry.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (out !== e.exp) begin
               n_bad++;
               $display("FAIL %s[%0d]: out=%b expected=%b", e.tag, e.idx, out, e.exp);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b1;
      In    = 1'b0;

      // Reset held two edges with In toggling: out stays low.
      apply(1'b1, "10", "00", "reset");

      // Single match, then low again.
      apply(1'b0, "10110", "00010", "single");

      // 16'hABCD LSB first: one pulse after bit index 3.
      apply(1'b1, "0", "0", "rst_a");
      apply(1'b0, "1011001111010101", "0001000000000000", "abcd");

      // Overlapping pattern.
      apply(1'b1, "0", "0", "rst_b");
`ifdef SEQ_DET_NO_OVERLAP_EN
      apply(1'b0, "1011011", "0001000", "overlap");
`else
      apply(1'b0, "1011011", "0001001", "overlap");
`endif

      // A registered pulse completes even when reset follows; reset clears out next.
      apply(1'b1, "0", "0", "rst_c");
      apply(1'b0, "1011", "0001", "pre_rst");
      apply(1'b1, "1", "0", "rst_after_hit");

      // Mid-stream reset discards the partial match.
      apply(1'b0, "101", "000", "partial");
      apply(1'b1, "0", "0", "rst_mid");
      apply(1'b0, "1", "0", "post_rst");
      apply(1'b0, "011", "001", "refill");

      // 32-bit mixed stream with hand-computed pulses.
      apply(1'b1, "0", "0", "rst_d");
`ifdef SEQ_DET_NO_OVERLAP_EN
      apply(1'b0, "11010110111011001011101101100010",
                  "00000010000001000001000100000000", "stream32");
`else
      apply(1'b0, "11010110111011001011101101100010",
                  "00000010010001000001000100100000", "stream32");
`endif

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
         @(posedge clk);
      end
      #3;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: entries_left=%0d expected=0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
